// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: issues DIV/DIVU, stalls the pipe until the
// result returns, delivers HI/LO with a write strobe, and annuls in-flight work on flush.
module div_issue_ctrl #(
  parameter int DATA_W        = 32,
  parameter int CANCEL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req_i,
  input  logic [4:0]          div_op_i,
  input  logic [DATA_W-1:0]   src_a_i,
  input  logic [DATA_W-1:0]   src_b_i,
  input  logic                flush_i,
  input  logic                ext_stall_i,
  input  logic                div_ready_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic [4:0]          div_op_o,
  output logic [DATA_W-1:0]   div_a_o,
  output logic [DATA_W-1:0]   div_b_o,
  output logic                stall_o,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                busy_o
);

  localparam int CW = (CANCEL_CYCLES < 1) ? 1 : $clog2(CANCEL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, CANCEL} state_e;

  typedef struct packed {
    logic [4:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } div_req_t;

  state_e            state_q;
  div_req_t          req_q;
  logic              start_q;
  logic              annul_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_req_i && !flush_i) begin
            req_q   <= '{op: div_op_i, a: src_a_i, b: src_b_i};
            start_q <= 1'b1;
            state_q <= WAIT;
          end
        end
        // Operands stay frozen here: the divider re-reads op and a during sign fix-up.
        WAIT: begin
          if (flush_i) begin
            start_q <= 1'b0;
            annul_q <= 1'b1;
            cnt_q   <= CW'(CANCEL_CYCLES);
            state_q <= CANCEL;
          end else if (div_ready_i) begin
            hi_q    <= div_result_i[2*DATA_W-1:DATA_W];
            lo_q    <= div_result_i[DATA_W-1:0];
            start_q <= 1'b0;
            state_q <= DONE;
          end
        end
        // Held while downstream stalls; repeated HI/LO writes of the same value are harmless.
        DONE: begin
          if (flush_i || !ext_stall_i) state_q <= IDLE;
        end
        CANCEL: begin
          if (cnt_q <= CW'(1)) begin
            annul_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      IDLE:    stall_o = div_req_i && !flush_i;
      WAIT:    stall_o = !flush_i;
      DONE:    stall_o = 1'b0;
      CANCEL:  stall_o = div_req_i;
      default: stall_o = 1'b0;
    endcase
  end

  assign hilo_we_o   = (state_q == DONE) && !flush_i;
  assign busy_o      = (state_q != IDLE);
  assign div_start_o = start_q;
  assign div_annul_o = annul_q;
  assign div_op_o    = req_q.op;
  assign div_a_o     = req_q.a;
  assign div_b_o     = req_q.b;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, spec vector table, hand corner sequences and
// randomized transactions checked against a transaction-level expectation.
module tb_div_issue_ctrl;
  localparam logic [4:0] DIV_OP  = 5'b11010;
  localparam logic [4:0] DIVU_OP = 5'b11011;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i, flush_i, ext_stall_i, div_ready_i;
  logic [4:0]  div_op_i;
  logic [31:0] src_a_i, src_b_i;
  logic [63:0] div_result_i;
  logic        div_start_o, div_annul_o, stall_o, hilo_we_o, busy_o;
  logic [4:0]  div_op_o;
  logic [31:0] div_a_o, div_b_o, hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  int n_we = 0;
  int n_annul = 0;
  int dcnt = 0;

  div_issue_ctrl #(.DATA_W(32), .CANCEL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_op_i(div_op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i), .ext_stall_i(ext_stall_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i), .div_start_o(div_start_o),
    .div_annul_o(div_annul_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] div_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return 64'd0;
    if (op == DIV_OP) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Divider: ready 35 cycles after start rises (3 for a zero divisor), held while start is high.
  always @(posedge clk) begin
    if (rst || !div_start_o || div_annul_o) dcnt <= 0;
    else if (dcnt < 99) dcnt <= dcnt + 1;
  end
  assign div_ready_i  = div_start_o && (dcnt == ((div_b_o == 32'd0) ? 3 : 35));
  assign div_result_i = div_ref(div_op_o, div_a_o, div_b_o);

  always @(negedge clk) begin
    if (hilo_we_o) n_we++;
    if (div_annul_o) n_annul++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a posedge with the DUT idle; holds the request like EX would.
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n_ext, input int flush_at,
                         output int stalls, output int wes, output int annuls,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output bit ok, output bit timeout);
    bit done, killed, seen;
    logic [4:0]  sop;
    logic [31:0] sa, sb;
    stalls = 0; wes = 0; annuls = 0; hi = '0; lo = '0;
    ok = 1; done = 0; killed = 0; seen = 0; sop = '0; sa = '0; sb = '0;
    div_req_i = 1; div_op_i = op; src_a_i = a; src_b_i = b; ext_stall_i = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      flush_i = (i == flush_at);
      @(negedge clk);
      if (stall_o) stalls++;
      if (div_annul_o) annuls++;
      if (div_start_o) begin
        if (!seen) begin seen = 1; sop = div_op_o; sa = div_a_o; sb = div_b_o; end
        else if (div_op_o != sop || div_a_o != sa || div_b_o != sb) ok = 0;
      end
      if (hilo_we_o) begin
        if (wes == 0) begin hi = hi_o; lo = lo_o; end
        else if (hi_o != hi || lo_o != lo) ok = 0;
        if (div_start_o) ok = 0;
        wes++;
        if (wes <= n_ext) ext_stall_i = 1;
        else begin ext_stall_i = 0; done = 1; end
      end
      if (killed && !busy_o) done = 1;
      if (flush_i) killed = 1;
      @(posedge clk); #1;
      if (killed || done) begin div_req_i = 0; ext_stall_i = 0; end
    end
    flush_i = 0;
    timeout = !done;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    int          n_ext;
    int          exp_stalls, exp_wes;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int stalls, wes, annuls, we0, an0;
    logic [31:0] hi, lo;
    bit ok, to;

    vecs[0] = '{DIVU_OP, 32'd100,        32'd7,          0, 37, 1, 32'd2,        32'd14};
    vecs[1] = '{DIV_OP,  32'hFFFFFFF9,   32'd2,          0, 37, 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{DIV_OP,  32'd5,          32'd0,          0,  5, 1, 32'd0,        32'd0};
    vecs[3] = '{DIVU_OP, 32'd100,        32'd7,          3, 37, 4, 32'd2,        32'd14};
    vecs[4] = '{DIVU_OP, 32'd9,          32'd3,          0, 37, 1, 32'd0,        32'd3};
    vecs[5] = '{DIV_OP,  32'd7,          32'hFFFFFFFE,   1, 37, 2, 32'd1,        32'hFFFFFFFD};
    vecs[6] = '{DIVU_OP, 32'hFFFFFFFF,   32'h10,         0, 37, 1, 32'hF,        32'h0FFFFFFF};
    vecs[7] = '{DIV_OP,  32'h80000000,   32'd2,          2, 37, 3, 32'd0,        32'hC0000000};

    rst = 1; div_req_i = 0; div_op_i = '0; src_a_i = '0; src_b_i = '0;
    flush_i = 0; ext_stall_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset outs", {div_start_o, div_annul_o, hilo_we_o, stall_o, busy_o, div_op_o}, 64'd0);
    chk("reset data", {div_a_o, div_b_o} | {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n_ext, -1, stalls, wes, annuls, hi, lo, ok, to);
      chk($sformatf("vec%0d timeout", i), to, 0);
      chk($sformatf("vec%0d stalls", i), stalls, vecs[i].exp_stalls);
      chk($sformatf("vec%0d hilo_we", i), wes, vecs[i].exp_wes);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("vec%0d stable", i), ok, 1);
    end

    // Flush 10 cycles into WAIT, next DIVU 9/3 waits through CANCEL then issues.
    we0 = n_we; an0 = n_annul;
    div_req_i = 1; div_op_i = DIVU_OP; src_a_i = 32'd1000; src_b_i = 32'd3;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1 flush_i = 1;
    @(negedge clk);
    chk("flush stall", stall_o, 0);
    chk("flush we", hilo_we_o, 0);
    @(posedge clk); #1;
    flush_i = 0; src_a_i = 32'd9; src_b_i = 32'd3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("cancel%0d annul", k), div_annul_o, 1);
      chk($sformatf("cancel%0d start", k), div_start_o, 0);
      chk($sformatf("cancel%0d stall", k), stall_o, 1);
      @(posedge clk); #1;
    end
    chk("cancel annul count", n_annul - an0, 2);
    chk("cancel no we", n_we - we0, 0);
    run_div(DIVU_OP, 32'd9, 32'd3, 0, -1, stalls, wes, annuls, hi, lo, ok, to);
    chk("post-cancel timeout", to, 0);
    chk("post-cancel stalls", stalls, 37);
    chk("post-cancel annul", annuls, 0);
    chk("post-cancel hilo", {hi, lo}, {32'd0, 32'd3});

    // Reset pulsed mid-WAIT.
    div_req_i = 1; div_op_i = DIVU_OP; src_a_i = 32'd50; src_b_i = 32'd5;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 rst = 1; div_req_i = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst outs", {div_start_o, div_annul_o, hilo_we_o, stall_o, busy_o, div_op_o}, 64'd0);
    chk("rst data", {div_a_o, div_b_o} | {hi_o, lo_o}, 64'd0);
    @(posedge clk); #1;
    run_div(DIVU_OP, 32'd100, 32'd7, 0, -1, stalls, wes, annuls, hi, lo, ok, to);
    chk("post-rst timeout", to, 0);
    chk("post-rst stalls", stalls, 37);
    chk("post-rst hilo", {hi, lo}, {32'd2, 32'd14});

    // Random transactions, some flushed in WAIT or DONE.
    for (int i = 0; i < 24; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [63:0] r;
      int tot, n_ext, f, e_st, e_we, e_an;
      op = ($urandom_range(0, 1) == 1) ? DIV_OP : DIVU_OP;
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      tot   = (b == 32'd0) ? 5 : 37;
      n_ext = $urandom_range(0, 2);
      f     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, tot) : -1;
      if (f < 0)        begin e_st = tot; e_we = n_ext + 1; e_an = 0; end
      else if (f < tot) begin e_st = f;   e_we = 0;         e_an = 2; end
      else              begin e_st = tot; e_we = 0;         e_an = 0; end
      r = div_ref(op, a, b);
      run_div(op, a, b, n_ext, f, stalls, wes, annuls, hi, lo, ok, to);
      chk($sformatf("rnd%0d timeout", i), to, 0);
      chk($sformatf("rnd%0d stalls", i), stalls, e_st);
      chk($sformatf("rnd%0d hilo_we", i), wes, e_we);
      chk($sformatf("rnd%0d annul", i), annuls, e_an);
      chk($sformatf("rnd%0d stable", i), ok, 1);
      if (e_we > 0) chk($sformatf("rnd%0d hilo", i), {hi, lo}, r);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
